primitive_job_scheduler: RTL and testbench
==========================================

PRIMITIVE_JOB_SCHEDULER -- requirements
Module: primitive_job_scheduler

Interface
REQ-001 SHALL have parameter MAX_TRIANGLE_COUNT, default 2048, max triangles per job; TW = $clog2(MAX_TRIANGLE_COUNT).
REQ-002 SHALL have parameter INDEX_BUFFER_DEPTH, default 8192, triangles in the shared index buffer; AW = $clog2(INDEX_BUFFER_DEPTH).
REQ-003 SHALL have parameter JOB_FIFO_DEPTH, default 4, power of two >= 2, queued jobs.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_job_valid / o_job_ready  in/out  1  job submit handshake; transfer when both high.
REQ-007 i_job_base  in  AW  first triangle index of job in index buffer.
REQ-008 i_job_num_tris  in  TW  triangle count of job.
REQ-009 i_job_last  in  1  job closes the current frame.
REQ-010 o_pa_start  out  1  one-cycle start pulse to primitive assembler.
REQ-011 o_pa_num_triangles  out  TW  held count for the running job.
REQ-012 i_pa_ready / i_pa_finished / i_pa_dv  in  1  assembler ready, finished pulse, primitive-valid pulse.
REQ-013 i_pa_tri_addr  in  TW  assembler-local triangle address; o_tri_addr  out  AW  = job base + i_pa_tri_addr, combinational, mod 2^AW.
REQ-014 o_busy  out  1  FIFO non-empty or state != IDLE; o_frame_done  out  1  one-cycle pulse; o_err  out  1  sticky job error.

Function
REQ-015 States SHALL be IDLE, LAUNCH, RUN, FRAME_DONE.
REQ-016 o_job_ready SHALL equal !fifo_full; push and pop in the same cycle SHALL both occur when not full; no bypass from input to head.
REQ-017 IDLE with FIFO non-empty SHALL pop head into job registers (base, count, last) and go to LAUNCH next cycle.
REQ-018 At pop, a job with i_job_base + num_tris > INDEX_BUFFER_DEPTH (computed AW+1 bits) SHALL set o_err, be discarded, and go to FRAME_DONE if last else IDLE.
REQ-019 At pop, a job with num_tris == 0 SHALL skip the assembler, go to FRAME_DONE if last else IDLE.
REQ-020 LAUNCH SHALL assert o_pa_start for exactly one cycle, the first cycle i_pa_ready is high, then go to RUN; it waits indefinitely otherwise.
REQ-021 RUN SHALL ignore i_pa_ready and, on i_pa_finished, go to FRAME_DONE if last else IDLE.
REQ-022 FRAME_DONE SHALL assert o_frame_done for one cycle and return to IDLE.
REQ-023 i_pa_finished outside RUN SHALL be ignored.
REQ-024 o_pa_num_triangles and job base SHALL remain stable from pop until leaving RUN.
REQ-025 Minimum latency from accepted job into empty FIFO (cycle N) to o_pa_start: cycle N+2 with i_pa_ready high.

Reset
REQ-026 While rst high: state IDLE, FIFO empty, o_job_ready 0, o_pa_start 0, o_frame_done 0, o_err 0, o_busy 0, job registers 0; o_job_ready rises the cycle after rst falls.
REQ-027 Reset mid-RUN SHALL discard queued and running jobs; no o_frame_done for them.

Configuration
REQ-028 Macro PRIM_JOB_SCHED_PERF_EN defined: adds outputs o_prim_count (32b, counts i_pa_dv in RUN) and o_frame_cycles (32b, cycles from first pop to o_frame_done), both cleared on reset and at first pop after FRAME_DONE, held after o_frame_done.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package render_pkg SHALL hold job_t struct (base, num_tris, last) and the state enum.
REQ-031 Job queue SHALL be sub-module job_fifo (synchronous, parameterised depth and job_t payload, full/empty flags).

Verification
REQ-032 Push job base=100 num=3 last=1, i_pa_ready=1 -> o_pa_start at N+2; i_pa_tri_addr=2 -> o_tri_addr=102; i_pa_finished -> o_frame_done next cycle.
REQ-033 Push 5 jobs back-to-back, depth 4, assembler held busy -> o_job_ready low after 4th; 5th accepted only after a pop; jobs run in order.
REQ-034 Job num=0 last=1 -> no o_pa_start, o_frame_done 2 cycles after acceptance, o_err stays 0.
REQ-035 Job base=8190 num=4 -> o_err set, no o_pa_start, next job executes normally.
REQ-036 Assert rst during RUN with 2 queued jobs -> all outputs reset values, no o_pa_start/o_frame_done after release until new job.
REQ-037 With PRIM_JOB_SCHED_PERF_EN: job num=7, seven i_pa_dv pulses -> o_prim_count=7 at o_frame_done.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg: job descriptor carried through the scheduler queue and the
// scheduler state encoding shared by the render front-end blocks.
package render_pkg;

  localparam int JOB_FIELD_W = 32;

  typedef struct packed {
    logic [JOB_FIELD_W-1:0] base;
    logic [JOB_FIELD_W-1:0] num_tris;
    logic                   last;
  } job_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_RUN        = 2'd2,
    ST_FRAME_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/job_fifo.sv
// job_fifo: synchronous job queue with wrap-bit pointers and full/empty flags.
// The head entry is presented combinationally on rd_data whenever not empty.
module job_fifo
  import render_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter type payload_t = job_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  payload_t wr_data,
  output payload_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  payload_t       mem_q [DEPTH];
  logic [PW:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is only meaningful behind the pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/primitive_job_scheduler.sv
// primitive_job_scheduler: queues render jobs and launches them one at a time on the
// primitive assembler. Define PRIM_JOB_SCHED_PERF_EN to add o_prim_count/o_frame_cycles.
module primitive_job_scheduler
  import render_pkg::*;
#(
  parameter  int MAX_TRIANGLE_COUNT = 2048,
  parameter  int INDEX_BUFFER_DEPTH = 8192,
  parameter  int JOB_FIFO_DEPTH     = 4,
  localparam int TW                 = $clog2(MAX_TRIANGLE_COUNT),
  localparam int AW                 = $clog2(INDEX_BUFFER_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_job_valid,
  output logic          o_job_ready,
  input  logic [AW-1:0] i_job_base,
  input  logic [TW-1:0] i_job_num_tris,
  input  logic          i_job_last,
  output logic          o_pa_start,
  output logic [TW-1:0] o_pa_num_triangles,
  input  logic          i_pa_ready,
  input  logic          i_pa_finished,
  input  logic          i_pa_dv,
  input  logic [TW-1:0] i_pa_tri_addr,
  output logic [AW-1:0] o_tri_addr,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_err
`ifdef PRIM_JOB_SCHED_PERF_EN
  ,
  output logic [31:0]   o_prim_count,
  output logic [31:0]   o_frame_cycles
`endif
);

  job_t          fifo_wr, fifo_rd;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  sched_state_e  state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [TW-1:0] num_q, num_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          ready_en_q, ready_en_d;
  logic [AW-1:0] head_base;
  logic [TW-1:0] head_num;
  logic [AW:0]   head_end;
  logic          head_bad;
  logic          head_unused;

  assign fifo_wr.base     = JOB_FIELD_W'(i_job_base);
  assign fifo_wr.num_tris = JOB_FIELD_W'(i_job_num_tris);
  assign fifo_wr.last     = i_job_last;

  // Ready is held low until the first edge after reset is released.
  assign o_job_ready = ready_en_q && !fifo_full;
  assign fifo_push   = i_job_valid && o_job_ready;

  job_fifo #(
    .DEPTH     (JOB_FIFO_DEPTH),
    .payload_t (job_t)
  ) u_job_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_base   = fifo_rd.base[AW-1:0];
  assign head_num    = fifo_rd.num_tris[TW-1:0];
  assign head_unused = ^{fifo_rd.base[JOB_FIELD_W-1:AW], fifo_rd.num_tris[JOB_FIELD_W-1:TW]};
  assign head_end    = {1'b0, head_base} + (AW+1)'(head_num);
  assign head_bad    = head_end > (AW+1)'(INDEX_BUFFER_DEPTH);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    last_d     = last_q;
    err_d      = err_q;
    ready_en_d = 1'b1;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          base_d   = head_base;
          num_d    = head_num;
          last_d   = fifo_rd.last;
          // Out-of-range and empty jobs never reach the assembler.
          if (head_bad) begin
            err_d   = 1'b1;
            state_d = fifo_rd.last ? ST_FRAME_DONE : ST_IDLE;
          end else if (head_num == '0) begin
            state_d = fifo_rd.last ? ST_FRAME_DONE : ST_IDLE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (i_pa_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_pa_finished) begin
          state_d = last_q ? ST_FRAME_DONE : ST_IDLE;
        end
      end
      ST_FRAME_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      last_q     <= last_d;
      err_q      <= err_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign o_pa_start         = (state_q == ST_LAUNCH) && i_pa_ready;
  assign o_frame_done       = (state_q == ST_FRAME_DONE);
  assign o_busy             = !fifo_empty || (state_q != ST_IDLE);
  assign o_err              = err_q;
  assign o_pa_num_triangles = num_q;
  assign o_tri_addr         = base_q + AW'(i_pa_tri_addr);

`ifdef PRIM_JOB_SCHED_PERF_EN
  logic        frame_open_q, frame_open_d;
  logic [31:0] prim_count_q, prim_count_d;
  logic [31:0] frame_cycles_q, frame_cycles_d;

  // A frame opens at its first pop and closes in the frame-done cycle; counts then hold.
  always_comb begin
    frame_open_d   = frame_open_q;
    prim_count_d   = prim_count_q;
    frame_cycles_d = frame_cycles_q;
    if (fifo_pop && !frame_open_q) begin
      frame_open_d   = 1'b1;
      prim_count_d   = '0;
      frame_cycles_d = 32'd1;
    end else if (frame_open_q) begin
      if (state_q == ST_FRAME_DONE) begin
        frame_open_d = 1'b0;
      end else begin
        frame_cycles_d = frame_cycles_q + 32'd1;
      end
      if ((state_q == ST_RUN) && i_pa_dv) begin
        prim_count_d = prim_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_open_q   <= 1'b0;
      prim_count_q   <= '0;
      frame_cycles_q <= '0;
    end else begin
      frame_open_q   <= frame_open_d;
      prim_count_q   <= prim_count_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign o_prim_count   = prim_count_q;
  assign o_frame_cycles = frame_cycles_q;
`else
  logic dv_unused;
  assign dv_unused = i_pa_dv;
`endif

endmodule

// File: tb/tb_primitive_job_scheduler.sv
// tb_primitive_job_scheduler: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based job model of the scheduler.
module tb_primitive_job_scheduler;

  localparam int MAXT = 2048;
  localparam int IBD  = 8192;
  localparam int QD   = 4;
  localparam int AW   = $clog2(IBD);
  localparam int TW   = $clog2(MAXT);

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FEND = 3;

  typedef struct {
    int base;
    int num;
    bit last;
  } job_s;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_job_valid = 1'b0;
  logic [AW-1:0] i_job_base = '0;
  logic [TW-1:0] i_job_num_tris = '0;
  logic          i_job_last = 1'b0;
  logic          i_pa_ready = 1'b0;
  logic          i_pa_finished = 1'b0;
  logic          i_pa_dv = 1'b0;
  logic [TW-1:0] i_pa_tri_addr = '0;
  logic          o_job_ready, o_pa_start, o_busy, o_frame_done, o_err;
  logic [TW-1:0] o_pa_num_triangles;
  logic [AW-1:0] o_tri_addr;
`ifdef PRIM_JOB_SCHED_PERF_EN
  logic [31:0]   o_prim_count, o_frame_cycles;
  int            prim_at_fd = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0, start_cyc = 0;
  int fd_cnt = 0, fd_cyc = 0;
  int start_log[$];

  job_s mq[$];
  int   m_phase = PH_IDLE;
  int   m_base = 0, m_num = 0;
  bit   m_last = 1'b0, m_err = 1'b0, m_armed = 1'b0;

  primitive_job_scheduler #(
    .MAX_TRIANGLE_COUNT (MAXT),
    .INDEX_BUFFER_DEPTH (IBD),
    .JOB_FIFO_DEPTH     (QD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_job_valid        (i_job_valid),
    .o_job_ready        (o_job_ready),
    .i_job_base         (i_job_base),
    .i_job_num_tris     (i_job_num_tris),
    .i_job_last         (i_job_last),
    .o_pa_start         (o_pa_start),
    .o_pa_num_triangles (o_pa_num_triangles),
    .i_pa_ready         (i_pa_ready),
    .i_pa_finished      (i_pa_finished),
    .i_pa_dv            (i_pa_dv),
    .i_pa_tri_addr      (i_pa_tri_addr),
    .o_tri_addr         (o_tri_addr),
    .o_busy             (o_busy),
    .o_frame_done       (o_frame_done),
    .o_err              (o_err)
`ifdef PRIM_JOB_SCHED_PERF_EN
    ,
    .o_prim_count       (o_prim_count),
    .o_frame_cycles     (o_frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input int base, input int num, input bit last);
    i_job_valid    = valid;
    i_job_base     = AW'(base);
    i_job_num_tris = TW'(num);
    i_job_last     = last;
  endtask

  // Job-level model: a queue of accepted jobs and the phase of the job taken from its head.
  task automatic modelStep();
    job_s j, nj;
    bit   accept;
    accept  = i_job_valid && m_armed && (mq.size() < QD);
    nj.base = int'(i_job_base);
    nj.num  = int'(i_job_num_tris);
    nj.last = i_job_last;
    case (m_phase)
      PH_IDLE: begin
        if (mq.size() > 0) begin
          j      = mq.pop_front();
          m_base = j.base;
          m_num  = j.num;
          m_last = j.last;
          if (j.base + j.num > IBD) begin
            m_err   = 1'b1;
            m_phase = j.last ? PH_FEND : PH_IDLE;
          end else if (j.num == 0) begin
            m_phase = j.last ? PH_FEND : PH_IDLE;
          end else begin
            m_phase = PH_WAIT;
          end
        end
      end
      PH_WAIT: if (i_pa_ready) m_phase = PH_RUN;
      PH_RUN:  if (i_pa_finished) m_phase = m_last ? PH_FEND : PH_IDLE;
      default: m_phase = PH_IDLE;
    endcase
    if (accept) mq.push_back(nj);
    m_armed = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_phase = PH_IDLE;
      m_armed = 1'b0;
      m_err   = 1'b0;
      m_base  = 0;
      m_num   = 0;
      m_last  = 1'b0;
    end else begin
      modelStep();
    end
  end

  task automatic compareCycle();
    checkOutput("job_ready", o_job_ready, (m_armed && mq.size() < QD) ? 1 : 0);
    checkOutput("pa_start", o_pa_start, (m_phase == PH_WAIT && i_pa_ready) ? 1 : 0);
    checkOutput("frame_done", o_frame_done, (m_phase == PH_FEND) ? 1 : 0);
    checkOutput("busy", o_busy, (mq.size() != 0 || m_phase != PH_IDLE) ? 1 : 0);
    checkOutput("err", o_err, m_err);
    if (m_phase == PH_WAIT || m_phase == PH_RUN) begin
      checkOutput("pa_num_triangles", o_pa_num_triangles, m_num);
      checkOutput("tri_addr", o_tri_addr, (m_base + int'(i_pa_tri_addr)) % IBD);
    end
    if (o_pa_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      start_log.push_back(int'(o_pa_num_triangles));
    end
    if (o_frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
`ifdef PRIM_JOB_SCHED_PERF_EN
      prim_at_fd = int'(o_prim_count);
`endif
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compareCycle();
    end
  end

  task automatic pushJob(input int base, input int num, input bit last, output int acc);
    int b = 0;
    while (!o_job_ready && b < 50) begin
      tick(1);
      b++;
    end
    if (!o_job_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_ready got=0 exp=1 (timed out)");
    end
    applyStimulus(1'b1, base, num, last);
    acc = cyc;
    tick(1);
    applyStimulus(1'b0, 0, 0, 1'b0);
  endtask

  task automatic waitStart(input int prev, input string name);
    int b = 0;
    while (start_cnt == prev && b < 200) begin
      tick(1);
      b++;
    end
    checkOutput(name, (start_cnt != prev) ? 1 : 0, 1);
  endtask

  task automatic waitFd(input int prev, input string name);
    int b = 0;
    while (fd_cnt == prev && b < 200) begin
      tick(1);
      b++;
    end
    checkOutput(name, (fd_cnt != prev) ? 1 : 0, 1);
  endtask

  task automatic pulseFinished(output int fc);
    @(posedge clk);
    #1;
    i_pa_finished = 1'b1;
    fc = cyc;
    tick(1);
    i_pa_finished = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, fc, prev_s, prev_f, b, idx;
    int exp_order[6];
    exp_order = '{5, 11, 12, 13, 14, 15};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_job_ready", o_job_ready, 0);
    checkOutput("reset_busy", o_busy, 0);
    rst = 1'b0;
    #1;
    checkOutput("release_job_ready_low", o_job_ready, 0);

    // Single job: start latency, address offset, frame-done after finish.
    i_pa_ready = 1'b1;
    prev_s = start_cnt;
    pushJob(100, 3, 1'b1, acc);
    waitStart(prev_s, "t1_start_seen");
    checkOutput("t1_start_latency", start_cyc - acc, 2);
    checkOutput("t1_num_tris", o_pa_num_triangles, 3);
    i_pa_tri_addr = TW'(2);
    @(negedge clk);
    checkOutput("t1_tri_addr", o_tri_addr, 102);
    prev_f = fd_cnt;
    pulseFinished(fc);
    waitFd(prev_f, "t1_fd_seen");
    checkOutput("t1_fd_latency", fd_cyc - fc, 1);

    // Empty job closing a frame.
    prev_s = start_cnt;
    prev_f = fd_cnt;
    pushJob(50, 0, 1'b1, acc);
    waitFd(prev_f, "t2_fd_seen");
    checkOutput("t2_fd_latency", fd_cyc - acc, 2);
    checkOutput("t2_no_start", start_cnt - prev_s, 0);
    checkOutput("t2_err_clear", o_err, 0);

    // Job ending exactly at the buffer end is legal.
    prev_s = start_cnt;
    pushJob(8188, 4, 1'b1, acc);
    waitStart(prev_s, "t3_edge_start_seen");
    checkOutput("t3_edge_no_err", o_err, 0);
    prev_f = fd_cnt;
    pulseFinished(fc);
    waitFd(prev_f, "t3_edge_fd_seen");

    // Job running past the buffer end is dropped and flagged; the next job runs.
    prev_s = start_cnt;
    pushJob(8190, 4, 1'b0, acc);
    tick(4);
    checkOutput("t3_err_set", o_err, 1);
    checkOutput("t3_err_no_start", start_cnt - prev_s, 0);
    pushJob(10, 2, 1'b1, acc);
    waitStart(prev_s, "t3_next_start_seen");
    checkOutput("t3_next_num", o_pa_num_triangles, 2);
    prev_f = fd_cnt;
    pulseFinished(fc);
    waitFd(prev_f, "t3_next_fd_seen");

    // Fill the queue behind a running job; the fifth job waits for a pop.
    prev_s = start_cnt;
    pushJob(200, 5, 1'b0, acc);
    waitStart(prev_s, "t4_a_start_seen");
    i_pa_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 210 + k * 20, 11 + k, 1'b0);
      tick(1);
    end
    applyStimulus(1'b1, 300, 15, 1'b1);
    checkOutput("t4_full_ready", o_job_ready, 0);
    tick(2);
    checkOutput("t4_still_full", o_job_ready, 0);
    pulseFinished(fc);
    b = 0;
    while (!o_job_ready && b < 20) begin
      tick(1);
      b++;
    end
    checkOutput("t4_ready_after_pop", o_job_ready, 1);
    tick(1);
    applyStimulus(1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      prev_s = start_cnt;
      i_pa_ready = 1'b1;
      waitStart(prev_s, "t4_drain_start_seen");
      pulseFinished(fc);
    end
    tick(3);
    idx = start_log.size() - 6;
    for (int k = 0; k < 6; k++) begin
      checkOutput("t4_order", (idx + k >= 0) ? start_log[idx + k] : -1, exp_order[k]);
    end

`ifdef PRIM_JOB_SCHED_PERF_EN
    prev_s = start_cnt;
    pushJob(400, 7, 1'b1, acc);
    waitStart(prev_s, "perf_start_seen");
    i_pa_dv = 1'b1;
    tick(7);
    i_pa_dv = 1'b0;
    prev_f = fd_cnt;
    pulseFinished(fc);
    waitFd(prev_f, "perf_fd_seen");
    checkOutput("perf_prim_count", prim_at_fd, 7);
`endif

    // Reset while running with two queued jobs.
    prev_s = start_cnt;
    pushJob(500, 6, 1'b0, acc);
    waitStart(prev_s, "t5_start_seen");
    pushJob(520, 7, 1'b0, acc);
    pushJob(540, 8, 1'b1, acc);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_busy", o_busy, 0);
    checkOutput("t5_rst_ready", o_job_ready, 0);
    checkOutput("t5_rst_start", o_pa_start, 0);
    checkOutput("t5_rst_num", o_pa_num_triangles, 0);
    tick(2);
    rst = 1'b0;
    prev_s = start_cnt;
    prev_f = fd_cnt;
    tick(15);
    checkOutput("t5_no_start_after", start_cnt - prev_s, 0);
    checkOutput("t5_no_fd_after", fd_cnt - prev_f, 0);
    checkOutput("t5_idle_busy", o_busy, 0);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      i_job_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0)
        i_job_base = AW'(IBD - 1 - int'($urandom_range(0, 24)));
      else
        i_job_base = AW'($urandom_range(0, IBD - 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      i_job_num_tris = '0;
      else if (r == 1) i_job_num_tris = TW'($urandom_range(0, MAXT - 1));
      else             i_job_num_tris = TW'($urandom_range(1, 30));
      i_job_last    = ($urandom_range(0, 2) == 0);
      i_pa_ready    = ($urandom_range(0, 2) != 0);
      i_pa_finished = ($urandom_range(0, 5) == 0);
      i_pa_dv       = ($urandom_range(0, 1) == 1);
      i_pa_tri_addr = TW'($urandom_range(0, MAXT - 1));
      tick(1);
    end
    applyStimulus(1'b0, 0, 0, 1'b0);
    i_pa_finished = 1'b0;
    i_pa_dv       = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
